// File: rtl/reg_bus_reader.sv
// Scans NrOfRegs tri-state bus registers one chip select at a time and streams each captured word out over valid/ready.
// Optional running arg-max outputs are enabled by defining REG_BUS_READER_ARGMAX_EN.
module reg_bus_reader #(
  parameter int unsigned NrOfBits     = 8,
  parameter int unsigned NrOfRegs     = 10,
  parameter int unsigned IndexBits    = 4,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ClockEnable,
  input  logic                 Tick,
  input  logic                 Start,
  input  logic [NrOfBits-1:0]  BusIn,
  output logic [NrOfRegs-1:0]  cs,
  output logic                 Busy,
  output logic [NrOfBits-1:0]  DataOut,
  output logic [IndexBits-1:0] IndexOut,
  output logic                 DataValid,
  input  logic                 DataReady,
`ifdef REG_BUS_READER_ARGMAX_EN
  output logic [NrOfBits-1:0]  MaxValue,
  output logic [IndexBits-1:0] MaxIndex,
`endif
  output logic                 Done
);

  typedef enum logic [1:0] {IDLE, SELECT, PRESENT, DONE} state_t;

  localparam logic [3:0]           SETTLE = 4'(SettleCycles);
  localparam logic [IndexBits-1:0] LAST   = IndexBits'(NrOfRegs - 1);

  state_t                 state_q, state_d;
  logic [IndexBits-1:0]   idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NrOfRegs-1:0]    cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic [NrOfBits-1:0]    data_q, data_d;
  logic [IndexBits-1:0]   index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   en;
`ifdef REG_BUS_READER_ARGMAX_EN
  logic [NrOfBits-1:0]    max_q, max_d;
  logic [IndexBits-1:0]   maxidx_q, maxidx_d;
`endif

  // Chip-select word with only register k pulled low.
  function automatic logic [NrOfRegs-1:0] sel_cs(input logic [IndexBits-1:0] k);
    logic [NrOfRegs-1:0] v;
    v = '1;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      if (i == 32'(k)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign en = ClockEnable & Tick;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    data_d   = data_q;
    index_d  = index_q;
    valid_d  = valid_q;
    done_d   = done_q;
`ifdef REG_BUS_READER_ARGMAX_EN
    max_d    = max_q;
    maxidx_d = maxidx_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            idx_d   = '0;
            cnt_d   = '0;
            cs_d    = sel_cs('0);
            busy_d  = 1'b1;
            state_d = SELECT;
`ifdef REG_BUS_READER_ARGMAX_EN
            max_d    = '0;
            maxidx_d = '0;
`endif
          end
        end
        SELECT: begin
          if (cnt_q == SETTLE) begin
            data_d  = BusIn;
            index_d = idx_q;
            valid_d = 1'b1;
            cs_d    = '1;
            cnt_d   = '0;
            state_d = PRESENT;
`ifdef REG_BUS_READER_ARGMAX_EN
            // Strict compare keeps the lowest index on ties; idx 0 seeds the max.
            if (idx_q == '0 || BusIn > max_q) begin
              max_d    = BusIn;
              maxidx_d = idx_q;
            end
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        PRESENT: begin
          if (DataReady) begin
            valid_d = 1'b0;
            if (idx_q == LAST) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              cs_d    = sel_cs(idx_q + 1'b1);
              state_d = SELECT;
            end
          end
        end
        DONE: begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      cs_q     <= '1;
      busy_q   <= 1'b0;
      data_q   <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef REG_BUS_READER_ARGMAX_EN
      max_q    <= '0;
      maxidx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef REG_BUS_READER_ARGMAX_EN
      max_q    <= max_d;
      maxidx_q <= maxidx_d;
`endif
    end
  end

  assign cs        = cs_q;
  assign Busy      = busy_q;
  assign DataOut   = data_q;
  assign IndexOut  = index_q;
  assign DataValid = valid_q;
  assign Done      = done_q;
`ifdef REG_BUS_READER_ARGMAX_EN
  assign MaxValue  = max_q;
  assign MaxIndex  = maxidx_q;
`endif

endmodule

// File: tb/tb_reg_bus_reader.sv
// Directed bench for reg_bus_reader (10 registers, SettleCycles=1); arg-max checks follow REG_BUS_READER_ARGMAX_EN.
module tb_reg_bus_reader;

  logic       Clock;
  logic       Reset;
  logic       ClockEnable;
  logic       Tick;
  logic       Start;
  logic [7:0] BusIn;
  logic [9:0] cs;
  logic       Busy;
  logic [7:0] DataOut;
  logic [3:0] IndexOut;
  logic       DataValid;
  logic       DataReady;
  logic       Done;
`ifdef REG_BUS_READER_ARGMAX_EN
  logic [7:0] MaxValue;
  logic [3:0] MaxIndex;
`endif

  logic [7:0]  regval [10];
  logic        tick_div;
  logic [1:0]  cyc;
  int          total;
  int          bad;
  int          done_total;
  logic        done_prev;
  logic        mon_en;
  logic [24:0] snap_prev;

  reg_bus_reader #(
    .NrOfBits(8), .NrOfRegs(10), .IndexBits(4), .SettleCycles(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .Start(Start), .BusIn(BusIn), .cs(cs), .Busy(Busy), .DataOut(DataOut),
    .IndexOut(IndexOut), .DataValid(DataValid), .DataReady(DataReady),
`ifdef REG_BUS_READER_ARGMAX_EN
    .MaxValue(MaxValue), .MaxIndex(MaxIndex),
`endif
    .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial cyc = 2'd0;
  always @(negedge Clock) cyc <= cyc + 2'd1;
  assign Tick = tick_div ? (cyc == 2'd0) : 1'b1;

  // Bus model: a selected register drives its value, otherwise the bus floats (0xEE marker).
  always_comb begin
    BusIn = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      if (!cs[k]) BusIn = regval[k];
    end
  end

  function automatic logic [9:0] sel(input int k);
    logic [9:0] one;
    one = 10'd1;
    return 10'h3FF ^ (one << k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge; invariants and hold-on-disabled-edge checked every cycle.
  task automatic step();
    logic        en_e, rst_e;
    logic [24:0] cur;
    @(posedge Clock);
    en_e  = ClockEnable & Tick;
    rst_e = Reset;
    #1;
    cur = {cs, Busy, DataValid, Done, DataOut, IndexOut};
    if (mon_en) begin
      if (!en_e && !rst_e) check("hold_disabled_edge", 32'(cur), 32'(snap_prev));
      check("cs_at_most_one_low", 32'($countones(~cs) <= 1), 32'd1);
      if (DataValid || !Busy) check("cs_released", 32'(cs), 32'h3FF);
      if (Done && !done_prev) done_total++;
    end
    done_prev = Done;
    snap_prev = cur;
  endtask

  task automatic start_pass(output int base);
    base  = done_total;
    Start = 1'b1;
    for (int n = 0; n < 60 && !Busy; n++) step();
    Start = 1'b0;
    check("start_busy", 32'(Busy), 32'd1);
    check("start_cs0", 32'(cs), 32'(sel(0)));
  endtask

  task automatic read_word(input int k, input logic [7:0] exp, input int stall);
    for (int n = 0; n < 60 && !DataValid; n++) step();
    check("valid_seen", 32'(DataValid), 32'd1);
    check("data", 32'(DataOut), 32'(exp));
    check("index", 32'(IndexOut), 32'(k));
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", 32'(DataValid), 32'd1);
      check("stall_data", 32'(DataOut), 32'(exp));
      check("stall_cs", 32'(cs), 32'h3FF);
    end
    DataReady = 1'b1;
    for (int n = 0; n < 60 && DataValid; n++) step();
    check("handshake_clears_valid", 32'(DataValid), 32'd0);
    DataReady = 1'b0;
  endtask

  task automatic finish_pass(input int base, input logic [7:0] emax, input logic [3:0] eidx);
    for (int n = 0; n < 60 && !Done; n++) step();
    check("done_pulse", 32'(Done), 32'd1);
`ifdef REG_BUS_READER_ARGMAX_EN
    check("max_value", 32'(MaxValue), 32'(emax));
    check("max_index", 32'(MaxIndex), 32'(eidx));
`else
    if (emax == 8'hFF && eidx == 4'hF) $display("note: argmax disabled");
`endif
    for (int n = 0; n < 60 && Busy; n++) step();
    check("end_busy", 32'(Busy), 32'd0);
    check("end_done", 32'(Done), 32'd0);
    check("done_count", 32'(done_total - base), 32'd1);
  endtask

  initial begin
    int base;
    total = 0; bad = 0; done_total = 0; done_prev = 1'b0; mon_en = 1'b0; snap_prev = '0;
    Reset = 1'b1; ClockEnable = 1'b1; tick_div = 1'b0; Start = 1'b0; DataReady = 1'b0;
    for (int k = 0; k < 10; k++) regval[k] = 8'h10 + 8'(k);
    step(); step();
    Reset = 1'b0;
    mon_en = 1'b1;
    check("rst_cs", 32'(cs), 32'h3FF);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(DataValid), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_data", 32'(DataOut), 32'd0);
    check("rst_index", 32'(IndexOut), 32'd0);

    // Basic scan with DataReady held high: exact cycle timing.
    base = done_total;
    DataReady = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    check("e0_cs", 32'(cs), 32'(sel(0)));
    check("e0_busy", 32'(Busy), 32'd1);
    step();
    check("e1_valid", 32'(DataValid), 32'd0);
    check("e1_cs", 32'(cs), 32'(sel(0)));
    step();
    check("e2_valid", 32'(DataValid), 32'd1);
    check("e2_data", 32'(DataOut), 32'h10);
    check("e2_index", 32'(IndexOut), 32'd0);
    for (int k = 1; k < 10; k++) begin
      step();
      check("b2b_valid_low", 32'(DataValid), 32'd0);
      check("b2b_cs", 32'(cs), 32'(sel(k)));
      step(); step();
      check("b2b_valid", 32'(DataValid), 32'd1);
      check("b2b_data", 32'(DataOut), 32'h10 + 32'(k));
      check("b2b_index", 32'(IndexOut), 32'(k));
    end
    step();
    check("basic_done", 32'(Done), 32'd1);
    check("basic_done_busy", 32'(Busy), 32'd1);
    step();
    check("basic_idle_done", 32'(Done), 32'd0);
    check("basic_idle_busy", 32'(Busy), 32'd0);
    check("basic_done_count", 32'(done_total - base), 32'd1);
    DataReady = 1'b0;

    // Backpressure on index 3.
    start_pass(base);
    for (int k = 0; k < 10; k++) read_word(k, 8'h10 + 8'(k), (k == 3) ? 5 : 0);
    finish_pass(base, 8'h19, 4'd9);

    // Tick on every 4th cycle.
    tick_div = 1'b1;
    start_pass(base);
    for (int k = 0; k < 10; k++) read_word(k, 8'h10 + 8'(k), (k == 6) ? 2 : 0);
    finish_pass(base, 8'h19, 4'd9);
    tick_div = 1'b0;
    for (int n = 0; n < 4; n++) step();

    // Reset while index 5 is selected, then a clean rescan.
    start_pass(base);
    for (int k = 0; k < 5; k++) read_word(k, 8'h10 + 8'(k), 0);
    check("pre_reset_cs5", 32'(cs), 32'(sel(5)));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_cs", 32'(cs), 32'h3FF);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_valid", 32'(DataValid), 32'd0);
    check("midrst_data", 32'(DataOut), 32'd0);
    check("midrst_index", 32'(IndexOut), 32'd0);
    start_pass(base);
    for (int k = 0; k < 10; k++) read_word(k, 8'h10 + 8'(k), 0);
    finish_pass(base, 8'h19, 4'd9);

    // Start pulsed while busy is ignored.
    start_pass(base);
    read_word(0, 8'h10, 0);
    read_word(1, 8'h11, 0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 2; k < 10; k++) read_word(k, 8'h10 + 8'(k), 0);
    finish_pass(base, 8'h19, 4'd9);

    // Start held through DONE launches the next pass straight from IDLE.
    start_pass(base);
    for (int k = 0; k < 9; k++) read_word(k, 8'h10 + 8'(k), 0);
    Start = 1'b1;
    read_word(9, 8'h19, 0);
    check("held_done", 32'(Done), 32'd1);
    step();
    check("held_idle_busy", 32'(Busy), 32'd0);
    step();
    check("held_restart_busy", 32'(Busy), 32'd1);
    check("held_restart_cs", 32'(cs), 32'(sel(0)));
    Start = 1'b0;
    base = done_total;
    for (int k = 0; k < 10; k++) read_word(k, 8'h10 + 8'(k), 0);
    finish_pass(base, 8'h19, 4'd9);

    // Arg-max data with ties: highest value 9 first seen at index 1.
    regval[0] = 8'd3; regval[1] = 8'd9; regval[2] = 8'd7; regval[3] = 8'd9; regval[4] = 8'd0;
    regval[5] = 8'd1; regval[6] = 8'd2; regval[7] = 8'd9; regval[8] = 8'd4; regval[9] = 8'd5;
    start_pass(base);
    for (int k = 0; k < 10; k++) read_word(k, regval[k], 0);
    finish_pass(base, 8'd9, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
